// File: rtl/csi_tx_pkg.sv
// csi_tx_pkg
// Shared definitions for the CSI-2 transmit lane controllers: the clock-lane
// state enum, the default timing constants (in byte-clock cycles), the lane
// timer width, the LP/HS driver bundle and small helpers to convert a timing
// parameter into a timer load value and a state into driver levels.
package csi_tx_pkg;

  localparam int CNT_W = 8;

  localparam int DEF_T_LPX     = 8;
  localparam int DEF_T_PREPARE = 6;
  localparam int DEF_T_ZERO    = 32;
  localparam int DEF_T_PRE     = 4;
  localparam int DEF_T_POST    = 16;
  localparam int DEF_T_TRAIL   = 8;
  localparam int DEF_T_EXIT    = 12;

  typedef enum logic [2:0] {
    ST_STOP,
    ST_LPX,
    ST_PREPARE,
    ST_ZERO,
    ST_HS_RUN,
    ST_POST,
    ST_TRAIL,
    ST_EXIT
  } clk_lane_state_t;

  typedef struct packed {
    logic lp_p;
    logic lp_n;
    logic hs_oe;
    logic hs_clk_en;
  } lane_drive_t;

  // A state lasting T cycles is timed by loading T-1 and advancing when the
  // counter reads zero. T is clamped to 1..255 so a zero parameter still
  // yields a one-cycle state and the value always fits the 8-bit timer.
  function automatic logic [CNT_W-1:0] timer_load(input int t);
    int c;
    c = t;
    if (c < 1) c = 1;
    if (c > 255) c = 255;
    return CNT_W'(c - 1);
  endfunction

  // Line levels driven in each state.
  function automatic lane_drive_t drive_for(input clk_lane_state_t s);
    lane_drive_t d;
    d = '{lp_p: 1'b1, lp_n: 1'b1, hs_oe: 1'b0, hs_clk_en: 1'b0};
    unique case (s)
      ST_STOP:    d = '{lp_p: 1'b1, lp_n: 1'b1, hs_oe: 1'b0, hs_clk_en: 1'b0};
      ST_LPX:     d = '{lp_p: 1'b0, lp_n: 1'b1, hs_oe: 1'b0, hs_clk_en: 1'b0};
      ST_PREPARE: d = '{lp_p: 1'b0, lp_n: 1'b0, hs_oe: 1'b0, hs_clk_en: 1'b0};
      ST_ZERO:    d = '{lp_p: 1'b0, lp_n: 1'b0, hs_oe: 1'b1, hs_clk_en: 1'b0};
      ST_HS_RUN:  d = '{lp_p: 1'b0, lp_n: 1'b0, hs_oe: 1'b1, hs_clk_en: 1'b1};
      ST_POST:    d = '{lp_p: 1'b0, lp_n: 1'b0, hs_oe: 1'b1, hs_clk_en: 1'b1};
      ST_TRAIL:   d = '{lp_p: 1'b0, lp_n: 1'b0, hs_oe: 1'b1, hs_clk_en: 1'b0};
      ST_EXIT:    d = '{lp_p: 1'b1, lp_n: 1'b1, hs_oe: 1'b0, hs_clk_en: 1'b0};
      default:    d = '{lp_p: 1'b1, lp_n: 1'b1, hs_oe: 1'b0, hs_clk_en: 1'b0};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/csi_tx_lane_timer.sv
// csi_tx_lane_timer
// Loadable down-counter used to time the LP/HS phases of a lane. A load wins
// over counting; otherwise the counter decrements and rests at zero.
// Ports:
//   clk      - byte clock
//   rst_n    - synchronous active-low reset, clears the counter
//   load     - load load_val this cycle
//   load_val - value to load (phase length minus one)
//   zero     - counter currently reads zero
module csi_tx_lane_timer
  import csi_tx_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // Counter register: reset to zero, load on request, otherwise count down
  // and hold once zero is reached so an idle timer stays quiet.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/csi_tx_clk_lane.sv
// csi_tx_clk_lane
// MIPI CSI-2 transmit clock-lane controller. Sequences the LP-11 -> LP-01 ->
// LP-00 -> HS-0 -> running clock startup, raises READY once the clock has run
// for T_PRE cycles, and after the data lanes go idle winds the clock down
// through POST, TRAIL and EXIT back to LP-11.
// Ports:
//   CLK_BYTE    - byte clock (HS bit clock / 4), the only clock
//   RST_N       - synchronous active-low reset
//   HS_REQ      - request to run the HS clock
//   DATA_ACTIVE - high while any data lane is in HS
//   LP_P, LP_N  - LP driver levels
//   HS_OE       - HS driver enable
//   HS_CLK_EN   - serializer sends 0101 when high, all-zero when low
//   READY       - data lanes may start HS
//   BUSY        - lane is anywhere but STOP
module csi_tx_clk_lane
  import csi_tx_pkg::*;
#(
  parameter int T_LPX     = DEF_T_LPX,
  parameter int T_PREPARE = DEF_T_PREPARE,
  parameter int T_ZERO    = DEF_T_ZERO,
  parameter int T_PRE     = DEF_T_PRE,
  parameter int T_POST    = DEF_T_POST,
  parameter int T_TRAIL   = DEF_T_TRAIL,
  parameter int T_EXIT    = DEF_T_EXIT
) (
  input  logic CLK_BYTE,
  input  logic RST_N,
  input  logic HS_REQ,
  input  logic DATA_ACTIVE,
  output logic LP_P,
  output logic LP_N,
  output logic HS_OE,
  output logic HS_CLK_EN,
  output logic READY,
  output logic BUSY
);

  localparam logic [CNT_W-1:0] LPX_LOAD     = timer_load(T_LPX);
  localparam logic [CNT_W-1:0] PREPARE_LOAD = timer_load(T_PREPARE);
  localparam logic [CNT_W-1:0] ZERO_LOAD    = timer_load(T_ZERO);
  localparam logic [CNT_W-1:0] PRE_LOAD     = timer_load(T_PRE);
  localparam logic [CNT_W-1:0] POST_LOAD    = timer_load(T_POST);
  localparam logic [CNT_W-1:0] TRAIL_LOAD   = timer_load(T_TRAIL);
  localparam logic [CNT_W-1:0] EXIT_LOAD    = timer_load(T_EXIT);

  clk_lane_state_t  state_q;
  clk_lane_state_t  state_d;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_zero;
  logic             ready_d;
  lane_drive_t      drive_d;
  logic             proto_err;

  csi_tx_lane_timer u_timer (
    .clk      (CLK_BYTE),
    .rst_n    (RST_N),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Next-state logic. Every timed state loads the timer for the state it is
  // about to enter; EXIT needs no load because the timer is already at zero
  // when STOP is reached. HS_REQ is only looked at in STOP (startup is never
  // aborted, and requests during wind-down wait for STOP), and HS_RUN is
  // left only once READY has been shown and both the request and the data
  // lanes are idle. READY is raised when the T_PRE count expires and held
  // for the rest of HS_RUN; it drops on the edge that leaves HS_RUN.
  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state_q)
      ST_STOP: begin
        if (HS_REQ) begin
          state_d  = ST_LPX;
          tmr_load = 1'b1;
          tmr_val  = LPX_LOAD;
        end
      end
      ST_LPX: begin
        if (tmr_zero) begin
          state_d  = ST_PREPARE;
          tmr_load = 1'b1;
          tmr_val  = PREPARE_LOAD;
        end
      end
      ST_PREPARE: begin
        if (tmr_zero) begin
          state_d  = ST_ZERO;
          tmr_load = 1'b1;
          tmr_val  = ZERO_LOAD;
        end
      end
      ST_ZERO: begin
        if (tmr_zero) begin
          state_d  = ST_HS_RUN;
          tmr_load = 1'b1;
          tmr_val  = PRE_LOAD;
        end
      end
      ST_HS_RUN: begin
        if (READY && !HS_REQ && !DATA_ACTIVE) begin
          state_d  = ST_POST;
          tmr_load = 1'b1;
          tmr_val  = POST_LOAD;
        end
      end
      ST_POST: begin
        if (tmr_zero) begin
          state_d  = ST_TRAIL;
          tmr_load = 1'b1;
          tmr_val  = TRAIL_LOAD;
        end
      end
      ST_TRAIL: begin
        if (tmr_zero) begin
          state_d  = ST_EXIT;
          tmr_load = 1'b1;
          tmr_val  = EXIT_LOAD;
        end
      end
      ST_EXIT: begin
        if (tmr_zero) begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d = ST_STOP;
      end
    endcase
    ready_d = (state_q == ST_HS_RUN) && (state_d == ST_HS_RUN) && (READY || tmr_zero);
    drive_d = drive_for(state_d);
  end

  // State and output registers. Outputs are decoded from the next state so
  // they switch on the same edge as the state itself. proto_err is a sticky
  // debug flag for data-lane activity while the clock is not running; it is
  // kept internal for waveform inspection.
  always_ff @(posedge CLK_BYTE) begin
    if (!RST_N) begin
      state_q   <= ST_STOP;
      LP_P      <= 1'b1;
      LP_N      <= 1'b1;
      HS_OE     <= 1'b0;
      HS_CLK_EN <= 1'b0;
      READY     <= 1'b0;
      BUSY      <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      LP_P      <= drive_d.lp_p;
      LP_N      <= drive_d.lp_n;
      HS_OE     <= drive_d.hs_oe;
      HS_CLK_EN <= drive_d.hs_clk_en;
      READY     <= ready_d;
      BUSY      <= (state_d != ST_STOP);
      proto_err <= proto_err | (DATA_ACTIVE && (state_q != ST_HS_RUN));
    end
  end

endmodule

// File: tb/tb_csi_tx_clk_lane.sv
// tb_csi_tx_clk_lane
// Bench for csi_tx_clk_lane. Two instances share the stimulus: dut0 with the
// default timing and dut1 with every timing at its minimum (some given as 0
// to exercise the clamp). Each cycle both are compared with a phase/elapsed
// reference model; a vector table and directed sequences add hand-derived
// expectations, followed by a randomized run.
module tb_csi_tx_clk_lane;

  localparam int P_STOP  = 0;
  localparam int P_LPX   = 1;
  localparam int P_PREP  = 2;
  localparam int P_ZERO  = 3;
  localparam int P_RUN   = 4;
  localparam int P_POST  = 5;
  localparam int P_TRAIL = 6;
  localparam int P_EXIT  = 7;

  // {lp_p, lp_n, hs_oe, hs_clk_en, ready, busy}
  localparam logic [5:0] V_STOP    = 6'b110000;
  localparam logic [5:0] V_LPX     = 6'b010001;
  localparam logic [5:0] V_PREP    = 6'b000001;
  localparam logic [5:0] V_ZERO    = 6'b001001;
  localparam logic [5:0] V_RUN     = 6'b001101;
  localparam logic [5:0] V_RUN_RDY = 6'b001111;
  localparam logic [5:0] V_POST    = 6'b001101;
  localparam logic [5:0] V_TRAIL   = 6'b001001;
  localparam logic [5:0] V_EXIT    = 6'b110001;

  typedef struct {
    logic       r;
    logic       hr;
    logic       da;
    logic [5:0] exp;
  } vec_t;

  logic clk;
  logic rst_n;
  logic hs_req;
  logic data_active;

  logic d0_lp_p, d0_lp_n, d0_hs_oe, d0_clk_en, d0_ready, d0_busy;
  logic d1_lp_p, d1_lp_n, d1_hs_oe, d1_clk_en, d1_ready, d1_busy;
  logic [5:0] out0;
  logic [5:0] out1;

  int total;
  int bad;
  int cycle;

  int m_phase   [2];
  int m_elapsed [2];
  bit m_ready   [2];
  int m_dur     [2][8];

  vec_t tbl [15];

  assign out0 = {d0_lp_p, d0_lp_n, d0_hs_oe, d0_clk_en, d0_ready, d0_busy};
  assign out1 = {d1_lp_p, d1_lp_n, d1_hs_oe, d1_clk_en, d1_ready, d1_busy};

  csi_tx_clk_lane dut0 (
    .CLK_BYTE    (clk),
    .RST_N       (rst_n),
    .HS_REQ      (hs_req),
    .DATA_ACTIVE (data_active),
    .LP_P        (d0_lp_p),
    .LP_N        (d0_lp_n),
    .HS_OE       (d0_hs_oe),
    .HS_CLK_EN   (d0_clk_en),
    .READY       (d0_ready),
    .BUSY        (d0_busy)
  );

  csi_tx_clk_lane #(
    .T_LPX     (1),
    .T_PREPARE (0),
    .T_ZERO    (1),
    .T_PRE     (1),
    .T_POST    (0),
    .T_TRAIL   (1),
    .T_EXIT    (0)
  ) dut1 (
    .CLK_BYTE    (clk),
    .RST_N       (rst_n),
    .HS_REQ      (hs_req),
    .DATA_ACTIVE (data_active),
    .LP_P        (d1_lp_p),
    .LP_N        (d1_lp_n),
    .HS_OE       (d1_hs_oe),
    .HS_CLK_EN   (d1_clk_en),
    .READY       (d1_ready),
    .BUSY        (d1_busy)
  );

  // Free-running byte clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int eff(input int t);
    if (t < 1) return 1;
    if (t > 255) return 255;
    return t;
  endfunction

  // Reference model: each lane is a phase plus the number of edges already
  // spent in it, stepped with the inputs seen at a clock edge.
  task automatic modelStep(input int k, input logic r, input logic hr, input logic da);
    if (!r) begin
      m_phase[k]   = P_STOP;
      m_elapsed[k] = 0;
      m_ready[k]   = 1'b0;
    end else if (m_phase[k] == P_STOP) begin
      if (hr) begin
        m_phase[k]   = P_LPX;
        m_elapsed[k] = 0;
      end
    end else if (m_phase[k] == P_RUN) begin
      if (m_ready[k] && !hr && !da) begin
        m_phase[k]   = P_POST;
        m_elapsed[k] = 0;
        m_ready[k]   = 1'b0;
      end else begin
        m_elapsed[k] = m_elapsed[k] + 1;
        if (m_elapsed[k] >= m_dur[k][P_RUN]) m_ready[k] = 1'b1;
      end
    end else begin
      m_elapsed[k] = m_elapsed[k] + 1;
      if (m_elapsed[k] >= m_dur[k][m_phase[k]]) begin
        m_phase[k]   = (m_phase[k] == P_EXIT) ? P_STOP : m_phase[k] + 1;
        m_elapsed[k] = 0;
      end
    end
  endtask

  function automatic logic [5:0] modelOut(input int k);
    int p;
    p = m_phase[k];
    return {(p == P_STOP || p == P_EXIT),
            (p == P_STOP || p == P_LPX || p == P_EXIT),
            (p >= P_ZERO && p <= P_TRAIL),
            (p == P_RUN || p == P_POST),
            m_ready[k],
            (p != P_STOP)};
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("[TB] FAIL %s cycle=%0d got=%b want=%b", name, cycle, act, exp);
    end
  endtask

  // Drive one cycle of inputs, step the model on the edge and compare both
  // lanes against it half a cycle later.
  task automatic applyStimulus(input logic r, input logic hr, input logic da);
    rst_n       = r;
    hs_req      = hr;
    data_active = da;
    @(posedge clk);
    cycle = cycle + 1;
    modelStep(0, r, hr, da);
    modelStep(1, r, hr, da);
    @(negedge clk);
    checkOutput("model_dut0", {2'b00, out0}, {2'b00, modelOut(0)});
    checkOutput("model_dut1", {2'b00, out1}, {2'b00, modelOut(1)});
  endtask

  task automatic holdCheck(input int n, input logic hr, input logic da, input logic [5:0] exp, input string name);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, hr, da);
      checkOutput(name, {2'b00, out0}, {2'b00, exp});
    end
  endtask

  task automatic startupToReady(input logic hr_after);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("lpx_entry", {2'b00, out0}, {2'b00, V_LPX});
    holdCheck(7,  hr_after, 1'b0, V_LPX,     "lpx");
    holdCheck(6,  hr_after, 1'b0, V_PREP,    "prepare");
    holdCheck(32, hr_after, 1'b0, V_ZERO,    "hs_zero");
    holdCheck(4,  hr_after, 1'b0, V_RUN,     "hs_run_pre");
    holdCheck(1,  hr_after, 1'b0, V_RUN_RDY, "ready_rise");
  endtask

  initial begin
    logic r, hr, da;
    total       = 0;
    bad         = 0;
    cycle       = 0;
    rst_n       = 1'b0;
    hs_req      = 1'b0;
    data_active = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_phase[k]   = P_STOP;
      m_elapsed[k] = 0;
      m_ready[k]   = 1'b0;
    end
    m_dur[0] = '{0, eff(8), eff(6), eff(32), eff(4), eff(16), eff(8), eff(12)};
    m_dur[1] = '{0, eff(1), eff(0), eff(1),  eff(1), eff(0),  eff(1), eff(0)};

    // Minimum-timing lane, one row per cycle.
    tbl[0]  = '{r: 1'b0, hr: 1'b0, da: 1'b0, exp: V_STOP};
    tbl[1]  = '{r: 1'b1, hr: 1'b1, da: 1'b0, exp: V_LPX};
    tbl[2]  = '{r: 1'b1, hr: 1'b0, da: 1'b0, exp: V_PREP};
    tbl[3]  = '{r: 1'b1, hr: 1'b0, da: 1'b0, exp: V_ZERO};
    tbl[4]  = '{r: 1'b1, hr: 1'b0, da: 1'b0, exp: V_RUN};
    tbl[5]  = '{r: 1'b1, hr: 1'b0, da: 1'b1, exp: V_RUN_RDY};
    tbl[6]  = '{r: 1'b1, hr: 1'b0, da: 1'b1, exp: V_RUN_RDY};
    tbl[7]  = '{r: 1'b1, hr: 1'b0, da: 1'b0, exp: V_POST};
    tbl[8]  = '{r: 1'b1, hr: 1'b1, da: 1'b0, exp: V_TRAIL};
    tbl[9]  = '{r: 1'b1, hr: 1'b1, da: 1'b0, exp: V_EXIT};
    tbl[10] = '{r: 1'b1, hr: 1'b1, da: 1'b0, exp: V_STOP};
    tbl[11] = '{r: 1'b1, hr: 1'b1, da: 1'b0, exp: V_LPX};
    tbl[12] = '{r: 1'b1, hr: 1'b1, da: 1'b0, exp: V_PREP};
    tbl[13] = '{r: 1'b0, hr: 1'b1, da: 1'b0, exp: V_STOP};
    tbl[14] = '{r: 1'b1, hr: 1'b0, da: 1'b0, exp: V_STOP};

    $display("[TB] minimum-timing vector table");
    for (int i = 0; i < 15; i++) begin
      applyStimulus(tbl[i].r, tbl[i].hr, tbl[i].da);
      checkOutput($sformatf("vec%0d", i), {2'b00, out1}, {2'b00, tbl[i].exp});
    end

    $display("[TB] reset state");
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("rst_outs", {2'b00, out0}, {2'b00, V_STOP});
    checkOutput("rst_count", dut0.u_timer.count, 8'd0);
    checkOutput("rst_proto_err", {7'd0, dut0.proto_err}, 8'd0);
    holdCheck(3, 1'b0, 1'b0, V_STOP, "idle");

    $display("[TB] default startup, data hold, wind-down");
    startupToReady(1'b1);
    holdCheck(20, 1'b0, 1'b1, V_RUN_RDY, "run_hold_data");
    holdCheck(16, 1'b0, 1'b0, V_POST,    "post");
    holdCheck(8,  1'b0, 1'b0, V_TRAIL,   "trail");
    holdCheck(12, 1'b0, 1'b0, V_EXIT,    "exit");
    holdCheck(2,  1'b0, 1'b0, V_STOP,    "stop_after_exit");

    $display("[TB] one-cycle request");
    startupToReady(1'b0);
    holdCheck(16, 1'b0, 1'b0, V_POST,  "post_on_ready");
    holdCheck(8,  1'b0, 1'b0, V_TRAIL, "trail2");
    holdCheck(12, 1'b0, 1'b0, V_EXIT,  "exit2");
    holdCheck(1,  1'b0, 1'b0, V_STOP,  "stop2");

    $display("[TB] request during trail");
    startupToReady(1'b1);
    holdCheck(16, 1'b0, 1'b0, V_POST,  "post3");
    holdCheck(3,  1'b0, 1'b0, V_TRAIL, "trail3_idle");
    holdCheck(5,  1'b1, 1'b0, V_TRAIL, "trail3_req");
    holdCheck(12, 1'b1, 1'b0, V_EXIT,  "exit3_req");
    holdCheck(1,  1'b1, 1'b0, V_STOP,  "stop_one_cycle");
    holdCheck(1,  1'b1, 1'b0, V_LPX,   "relaunch");

    $display("[TB] reset in hs_run");
    holdCheck(7,  1'b1, 1'b0, V_LPX,  "lpx4");
    holdCheck(6,  1'b1, 1'b0, V_PREP, "prepare4");
    holdCheck(32, 1'b1, 1'b0, V_ZERO, "hs_zero4");
    holdCheck(2,  1'b1, 1'b0, V_RUN,  "hs_run4");
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("rst_mid_run", {2'b00, out0}, {2'b00, V_STOP});
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("req_after_rst", {2'b00, out0}, {2'b00, V_LPX});
    applyStimulus(1'b0, 1'b0, 1'b0);

    $display("[TB] data activity outside hs_run");
    checkOutput("proto_err_clear", {7'd0, dut0.proto_err}, 8'd0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("stop_ignores_data", {2'b00, out0}, {2'b00, V_STOP});
    checkOutput("proto_err_set", {7'd0, dut0.proto_err}, 8'd1);
    applyStimulus(1'b0, 1'b0, 1'b0);

    $display("[TB] randomized run");
    hr = 1'b0;
    da = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      r = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 24) == 0) hr = ~hr;
      if ($urandom_range(0, 9) == 0) da = ~da;
      applyStimulus(r, hr, da);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/csi_tx_clk_lane.md
CSI_TX_CLK_LANE -- requirements
Module: csi_tx_clk_lane

Interface
REQ-001 SHALL have parameter T_LPX, default 8, LP-01 duration in CLK_BYTE cycles.
REQ-002 SHALL have parameter T_PREPARE, default 6, LP-00 duration in cycles.
REQ-003 SHALL have parameter T_ZERO, default 32, HS-0 duration before the clock starts toggling.
REQ-004 SHALL have parameter T_PRE, default 4, cycles of running clock before READY asserts.
REQ-005 SHALL have parameter T_POST, default 16, cycles of running clock after data lanes go idle.
REQ-006 SHALL have parameter T_TRAIL, default 8, HS-0 duration after the clock stops.
REQ-007 SHALL have parameter T_EXIT, default 12, minimum LP-11 time before the next request.
REQ-008 SHALL have port CLK_BYTE, input, 1 bit: the only clock, the byte clock (HS bit clock / 4).
REQ-009 SHALL have port RST_N, input, 1 bit: reset, synchronous, active-low.
REQ-010 SHALL have port HS_REQ, input, 1 bit: request to run the HS clock.
REQ-011 SHALL have port DATA_ACTIVE, input, 1 bit: high while any data lane is in HS.
REQ-012 SHALL have port LP_P, output, 1 bit: LP driver, P line.
REQ-013 SHALL have port LP_N, output, 1 bit: LP driver, N line.
REQ-014 SHALL have port HS_OE, output, 1 bit: HS driver enable.
REQ-015 SHALL have port HS_CLK_EN, output, 1 bit: 1 = serializer sends the 0101 pattern, 0 = sends all-zero.
REQ-016 SHALL have port READY, output, 1 bit: data lanes may start HS.
REQ-017 SHALL have port BUSY, output, 1 bit: high in every state except STOP.

Function
REQ-018 SHALL implement these states and outputs, as (LP_P, LP_N, HS_OE, HS_CLK_EN):
- STOP: (1, 1, 0, 0)
- LPX: (0, 1, 0, 0)
- PREPARE: (0, 0, 0, 0)
- ZERO: (0, 0, 1, 0)
- HS_RUN: (0, 0, 1, 1)
- POST: (0, 0, 1, 1)
- TRAIL: (0, 0, 1, 0)
- EXIT: (1, 1, 0, 0)
REQ-019 SHALL register all outputs; each output changes on the same edge as the state change.
REQ-020 SHALL move STOP->LPX on the first edge with HS_REQ=1.
REQ-021 SHALL then step LPX->PREPARE->ZERO->HS_RUN, staying exactly T_LPX, T_PREPARE and T_ZERO cycles in the respective states.
REQ-022 SHALL assert READY after T_PRE cycles in HS_RUN, and hold it until HS_RUN is left.
REQ-023 SHALL deassert READY on the same edge the state machine enters POST.
REQ-024 SHALL move HS_RUN->POST on an edge where HS_REQ=0, DATA_ACTIVE=0 and READY=1.
REQ-025 SHALL step POST->TRAIL->EXIT->STOP, staying exactly T_POST, T_TRAIL and T_EXIT cycles in the respective states.
REQ-026 SHALL, if HS_REQ drops during LPX, PREPARE or ZERO, complete the startup and leave HS_RUN only once READY=1; a startup is never aborted.
REQ-027 SHALL ignore HS_REQ during POST, TRAIL and EXIT; a pending request is served from STOP, so STOP lasts at least 1 cycle between bursts.
REQ-028 SHALL stay in HS_RUN while DATA_ACTIVE=1, regardless of HS_REQ.
REQ-029 SHALL use one 8-bit down-counter, loaded with (T_x - 1) on state entry; the state advances when the counter reaches 0.
REQ-030 SHALL restrict every T_x to the range 1..255; a value of 0 is treated as 1 (elaboration-time clamp).
REQ-031 SHALL produce nothing on DATA_ACTIVE=1 outside HS_RUN except a sticky PROTO_ERR flag, visible in simulation only.

Reset
REQ-032 SHALL, on RST_N=0 at a CLK_BYTE edge, enter STOP with LP_P=1, LP_N=1, HS_OE=0, HS_CLK_EN=0, READY=0, BUSY=0 and the counter at 0.
REQ-033 SHALL apply reset mid-burst (including in HS_RUN) within 1 cycle, with no TRAIL or EXIT sequence.
REQ-034 SHALL, after reset release, accept HS_REQ on the first following edge.

Structure
REQ-035 SHALL place the state enum, the default T_x constants and the counter width (8) in the shared package csi_tx_pkg.
REQ-036 SHALL use one sub-module, csi_tx_lane_timer (loadable 8-bit down-counter with zero flag), which the data-lane controllers will reuse.
REQ-037 SHALL contain no vendor primitives; the IO buffers and serializer live outside this block.

Verification
REQ-038 SHALL cover: defaults, HS_REQ pulsed high at cycle 10 -> LP-01 at cycles 11-18, LP-00 at 19-24, HS-0 at 25-56, HS_CLK_EN=1 from 57, READY=1 from 61.
REQ-039 SHALL cover: READY=1, HS_REQ=0, DATA_ACTIVE held 1 for 20 more cycles -> HS_RUN held; POST 16 cycles, TRAIL 8, EXIT 12, then STOP with BUSY=0.
REQ-040 SHALL cover: HS_REQ=1 for 1 cycle only -> full startup, then POST entered the cycle READY rises.
REQ-041 SHALL cover: HS_REQ reasserted mid-TRAIL -> EXIT completes, 1 STOP cycle, then LPX.
REQ-042 SHALL cover: RST_N=0 for 1 cycle during HS_RUN -> next edge LP=11, HS_OE=0, READY=0, with no POST.
REQ-043 SHALL cover: all T_x=1 -> each state lasts 1 cycle, READY 1 cycle after HS_RUN entry.
